// File: rtl/act_cfg_pkg.sv
// Shared types and constants for the S2 cell configuration loader.
// Frame geometry helpers used by the loader and its shadow register.
package act_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        COMMIT
    } state_t;

    localparam int NUM_FIELDS = 4;

    localparam int F_D00 = 0;
    localparam int F_D01 = 1;
    localparam int F_D10 = 2;
    localparam int F_D11 = 3;

    function automatic int frame_len(input int ncells, input int xlen);
        return ncells * NUM_FIELDS * xlen;
    endfunction

    function automatic int idx_width(input int frame);
        return (frame > 1) ? $clog2(frame) : 1;
    endfunction

endpackage

// File: rtl/act_cfg_shift_reg.sv
// Frame-wide shadow register written one bit at a time by index,
// unpacked into the four per-field bus views (ACT_CFG_PARITY_EN adds odd).
module act_cfg_shift_reg
    import act_cfg_pkg::*;
#(
    parameter int XLEN   = 2,
    parameter int NCELLS = 4,
    parameter int FRAME  = frame_len(NCELLS, XLEN),
    parameter int IW     = idx_width(FRAME)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_idx,
    input  logic                   wr_bit,
`ifdef ACT_CFG_PARITY_EN
    output logic                   odd,
`endif
    output logic [NCELLS*XLEN-1:0] d00,
    output logic [NCELLS*XLEN-1:0] d01,
    output logic [NCELLS*XLEN-1:0] d10,
    output logic [NCELLS*XLEN-1:0] d11
);

    logic [FRAME-1:0] shadow;

    // Shadow is cleared on reset or a new frame, else written bit by bit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow[wr_idx] <= wr_bit;
        end
    end

`ifdef ACT_CFG_PARITY_EN
    assign odd = ^shadow;
`endif

    for (genvar c = 0; c < NCELLS; c++) begin : g_cell
        localparam int BASE = c * NUM_FIELDS * XLEN;
        for (genvar b = 0; b < XLEN; b++) begin : g_bit
            assign d00[c*XLEN+b] = shadow[BASE + F_D00*XLEN + b];
            assign d01[c*XLEN+b] = shadow[BASE + F_D01*XLEN + b];
            assign d10[c*XLEN+b] = shadow[BASE + F_D10*XLEN + b];
            assign d11[c*XLEN+b] = shadow[BASE + F_D11*XLEN + b];
        end
    end

endmodule

// File: rtl/act_s2_cfg_loader.sv
// Serial frame loader with atomic commit to the S2 cell data buses.
// Optional even-parity trailer bit enabled by ACT_CFG_PARITY_EN.
module act_s2_cfg_loader
    import act_cfg_pkg::*;
#(
    parameter int XLEN   = 2,
    parameter int NCELLS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cfg_bit,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic [NCELLS*XLEN-1:0] d00_bus,
    output logic [NCELLS*XLEN-1:0] d01_bus,
    output logic [NCELLS*XLEN-1:0] d10_bus,
    output logic [NCELLS*XLEN-1:0] d11_bus
);

    localparam int FRAME = frame_len(NCELLS, XLEN);
    localparam int CW    = idx_width(FRAME);
    localparam int BW    = NCELLS * XLEN;

    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          xfer;
    logic          sh_clr;
    logic          sh_wr;
    logic          commit;
    logic [BW-1:0] v00;
    logic [BW-1:0] v01;
    logic [BW-1:0] v10;
    logic [BW-1:0] v11;

`ifdef ACT_CFG_PARITY_EN
    logic odd;
    logic err_set;
    logic err_clr;
`endif

    assign xfer = cfg_valid & cfg_ready;

    act_cfg_shift_reg #(
        .XLEN   (XLEN),
        .NCELLS (NCELLS),
        .FRAME  (FRAME),
        .IW     (CW)
    ) u_shadow (
        .clock  (clock),
        .reset  (reset),
        .clear  (sh_clr),
        .wr_en  (sh_wr),
        .wr_idx (cnt),
        .wr_bit (cfg_bit),
`ifdef ACT_CFG_PARITY_EN
        .odd    (odd),
`endif
        .d00    (v00),
        .d01    (v01),
        .d10    (v10),
        .d11    (v11)
    );

    // Next-state, counter and strobe decode; abort beats any transfer.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cfg_ready = 1'b0;
        busy      = (state != IDLE);
        sh_clr    = 1'b0;
        sh_wr     = 1'b0;
        commit    = 1'b0;
`ifdef ACT_CFG_PARITY_EN
        err_set   = 1'b0;
        err_clr   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    sh_clr   = 1'b1;
`ifdef ACT_CFG_PARITY_EN
                    err_clr  = 1'b1;
`endif
                end
            end
            SHIFT: begin
                cfg_ready = 1'b1;
                if (abort) begin
                    state_nx = IDLE;
                end else if (xfer) begin
                    sh_wr  = 1'b1;
                    cnt_nx = cnt + 1'b1;
                    if (cnt == LAST) begin
`ifdef ACT_CFG_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = COMMIT;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef ACT_CFG_PARITY_EN
                cfg_ready = 1'b1;
                if (abort) begin
                    state_nx = IDLE;
                end else if (xfer) begin
                    if (odd ^ cfg_bit) begin
                        err_set  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = COMMIT;
                    end
                end
`else
                state_nx = IDLE;
`endif
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counter, done pulse and the active buses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cfg_done <= 1'b0;
            d00_bus  <= '0;
            d01_bus  <= '0;
            d10_bus  <= '0;
            d11_bus  <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cfg_done <= commit;
            if (commit) begin
                d00_bus <= v00;
                d01_bus <= v01;
                d10_bus <= v10;
                d11_bus <= v11;
            end
        end
    end

`ifdef ACT_CFG_PARITY_EN
    // Sticky parity error: set on a bad trailer, cleared by a new start.
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else if (err_clr) begin
            cfg_err <= 1'b0;
        end else if (err_set) begin
            cfg_err <= 1'b1;
        end
    end
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_act_s2_cfg_loader.sv
// Directed bench for act_s2_cfg_loader (NCELLS=4, XLEN=2, FRAME=32).
// Parity steps are included when ACT_CFG_PARITY_EN is defined.
module tb_act_s2_cfg_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       cfg_bit;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [7:0] d00_bus;
    logic [7:0] d01_bus;
    logic [7:0] d10_bus;
    logic [7:0] d11_bus;

    int vectors = 0;
    int miscmp  = 0;

    act_s2_cfg_loader #(.XLEN(2), .NCELLS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .d00_bus   (d00_bus),
        .d01_bus   (d01_bus),
        .d10_bus   (d10_bus),
        .d11_bus   (d11_bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [31:0] exp);
        chk(tag, {d11_bus, d10_bus, d01_bus, d00_bus}, exp);
    endtask

    // Start pulse, 32 data bits LSB first, optional idle gaps, then trailer.
    task automatic send_frame(input logic [31:0] data, input bit gap, input bit par);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (gap && (k % 2 == 1)) begin
                cfg_valid = 1'b0;
                cfg_bit   = ~data[k];
                step();
            end
            cfg_valid = 1'b1;
            cfg_bit   = data[k];
            step();
        end
`ifdef ACT_CFG_PARITY_EN
        cfg_bit = par;
        step();
`endif
        cfg_valid = 1'b0;
        cfg_bit   = par;
    endtask

    // Called with the FSM in COMMIT; buses word = {d11,d10,d01,d00}.
    task automatic check_commit(input string tag, input logic [31:0] exp, input bit ab);
        chk({tag, "_busy_in_commit"}, busy, 1);
        chk({tag, "_ready_in_commit"}, cfg_ready, 0);
        chk({tag, "_done_early"}, cfg_done, 0);
        abort = ab;
        step();
        abort = 1'b0;
        chk({tag, "_done"}, cfg_done, 1);
        chk({tag, "_busy_fall"}, busy, 0);
        chk_bus({tag, "_buses"}, exp);
        step();
        chk({tag, "_done_once"}, cfg_done, 0);
        chk_bus({tag, "_hold"}, exp);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_bit   = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        chk_bus("rst_buses", 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        reset = 1'b0;
        step();

        // Pattern A5C3_1E0F: d00=7B d01=4F d10=84 d11=B0.
        send_frame(32'hA5C3_1E0F, 1'b0, 1'b0);
        check_commit("pat", 32'hB084_4F7B, 1'b0);
        chk("pat_err", cfg_err, 0);

        // All-ones via gapped transfers.
        send_frame(32'hFFFF_FFFF, 1'b1, 1'b0);
        check_commit("ones_gap", 32'hFFFF_FFFF, 1'b0);

        // Same pattern with gaps gives identical buses.
        send_frame(32'hA5C3_1E0F, 1'b1, 1'b0);
        check_commit("pat_gap", 32'hB084_4F7B, 1'b0);

        // Abort after 10 bits keeps all-ones.
        send_frame(32'hFFFF_FFFF, 1'b0, 1'b0);
        check_commit("ones", 32'hFFFF_FFFF, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("shift_ready", cfg_ready, 1);
        chk("shift_busy", busy, 1);
        for (int k = 0; k < 10; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b0;
            step();
        end
        cfg_valid = 1'b0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", cfg_done, 0);
        step();
        chk("abort_done2", cfg_done, 0);
        chk_bus("abort_buses", 32'hFFFF_FFFF);

        // start and abort together in IDLE: stay idle.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_idle_busy", busy, 0);
        chk("sa_idle_ready", cfg_ready, 0);

        // Reset at bit 20 clears active buses.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        chk_bus("midrst_buses", 32'h0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cfg_ready, 0);
        step();
        chk_bus("midrst_hold", 32'h0);

        // FFFF_0000: cells 2,3 all ones -> every bus F0.
        send_frame(32'hFFFF_0000, 1'b0, 1'b0);
        check_commit("post_rst", 32'hF0F0_F0F0, 1'b0);

        // start inside SHIFT and abort inside COMMIT are both ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            start     = (k == 16);
            cfg_valid = 1'b1;
            cfg_bit   = k[0] ? 1'b1 : 1'b0;
            cfg_bit   = (32'hA5C3_1E0F >> k) & 32'h1;
            step();
        end
        start = 1'b0;
`ifdef ACT_CFG_PARITY_EN
        cfg_bit = 1'b0;
        step();
`endif
        cfg_valid = 1'b0;
        check_commit("ign", 32'hB084_4F7B, 1'b1);

`ifdef ACT_CFG_PARITY_EN
        // Bad trailer: error, no commit.
        send_frame(32'h0000_0001, 1'b0, 1'b0);
        chk("par_bad_err", cfg_err, 1);
        chk("par_bad_busy", busy, 0);
        step();
        chk("par_bad_done", cfg_done, 0);
        chk("par_bad_sticky", cfg_err, 1);
        chk_bus("par_bad_buses", 32'hB084_4F7B);
        // Good trailer: commit, error cleared.
        send_frame(32'h0000_0001, 1'b0, 1'b1);
        chk("par_good_err", cfg_err, 0);
        check_commit("par_good", 32'h0000_0001, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
